// File: rtl/sc_pkg.sv
// Shared definitions for the shift-bank slice: synchronous operation priorities,
// the per-stage operation encoding and width helpers for the fill counter.
package sc_pkg;

    // Synchronous request priorities; a higher number wins when several are raised.
    localparam int PRI_HOLD  = 0;
    localparam int PRI_SHIFT = 1;
    localparam int PRI_LOAD  = 2;
    localparam int PRI_CLR   = 3;

    // Resolved per-edge operation broadcast to every stage.
    typedef enum logic [1:0] {
        OP_HOLD  = 2'(PRI_HOLD),
        OP_SHIFT = 2'(PRI_SHIFT),
        OP_LOAD  = 2'(PRI_LOAD),
        OP_CLR   = 2'(PRI_CLR)
    } op_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a counter that must hold 0..depth inclusive, never narrower than one bit.
    function automatic int fill_width(input int depth);
        int w;
        w = clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_shift_bank_if.sv
// Control, data and status bundle of the shift bank. The master side drives the
// enables, load image and serial sample; the slave side returns taps, oldest
// sample and occupancy.
interface dff_shift_bank_if
    import sc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter int FILL_W = fill_width(DEPTH)
);

    logic                     CLR;
    logic                     LOAD_EN;
    logic [DEPTH*WIDTH-1:0]   LOAD_DATA;
    logic                     SHIFT_EN;
    logic [WIDTH-1:0]         D;
    logic [WIDTH-1:0]         Q;
    logic [DEPTH*WIDTH-1:0]   TAPS;
    logic [FILL_W-1:0]        FILL;
    logic                     FULL;

    modport master (
        output CLR,
        output LOAD_EN,
        output LOAD_DATA,
        output SHIFT_EN,
        output D,
        input  Q,
        input  TAPS,
        input  FILL,
        input  FULL
    );

    modport slave (
        input  CLR,
        input  LOAD_EN,
        input  LOAD_DATA,
        input  SHIFT_EN,
        input  D,
        output Q,
        output TAPS,
        output FILL,
        output FULL
    );

endinterface

// File: rtl/sc_dff_stage.sv
// One WIDTH-bit stage of the bank. Asynchronous reset to RESET_VAL; on each clock
// edge it clears, loads its slice of the load image, takes its upstream neighbour
// (shift) or holds, as selected by the already-resolved operation.
module sc_dff_stage
    import sc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  op_e              op,
    input  logic [WIDTH-1:0] load_d,
    input  logic [WIDTH-1:0] shift_d,
    output logic [WIDTH-1:0] q
);

    // Stage register: async reset, then clear / load / shift / hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else begin
            case (op)
                OP_CLR:   q <= RESET_VAL;
                OP_LOAD:  q <= load_d;
                OP_SHIFT: q <= shift_d;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/dff_shift_bank.sv
// WIDTH x DEPTH register bank used as the pixel delay line / window shifter.
// The top level resolves the clear > load > shift > hold priority once, hands the
// single resolved operation to every stage, and keeps the saturating fill counter
// and the registered FULL flag. Every output comes straight from a register.
module dff_shift_bank
    import sc_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    dff_shift_bank_if.slave  bus
);

    localparam int                FILL_W   = fill_width(DEPTH);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    op_e                    op;
    logic [WIDTH-1:0]       stage_q  [DEPTH];
    logic [WIDTH-1:0]       shift_in [DEPTH];
    logic [DEPTH*WIDTH-1:0] taps;
    logic [FILL_W-1:0]      fill_q;
    logic [FILL_W-1:0]      fill_nxt;
    logic                   full_q;

    // Priority decode: exactly one operation per edge, lower requests dropped whole.
    always_comb begin
        op = OP_HOLD;
        if (bus.CLR) begin
            op = OP_CLR;
        end else if (bus.LOAD_EN) begin
            op = OP_LOAD;
        end else if (bus.SHIFT_EN) begin
            op = OP_SHIFT;
        end
    end

    // Stage chain: stage 0 takes the serial input, stage i takes stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign shift_in[i] = bus.D;
        end else begin : g_link
            assign shift_in[i] = stage_q[i-1];
        end

        sc_dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (CLK),
            .rst     (RESET),
            .op      (op),
            .load_d  (bus.LOAD_DATA[i*WIDTH +: WIDTH]),
            .shift_d (shift_in[i]),
            .q       (stage_q[i])
        );
    end

    // Flatten the stage array into the tap bus, stage i at bits [i*WIDTH +: WIDTH].
    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            taps[i*WIDTH +: WIDTH] = stage_q[i];
        end
    end

    // Next occupancy: cleared, forced full on load, +1 per shift saturating at DEPTH.
    always_comb begin
        fill_nxt = fill_q;
        case (op)
            OP_CLR:  fill_nxt = '0;
            OP_LOAD: fill_nxt = FILL_MAX;
            OP_SHIFT: begin
                if (fill_q != FILL_MAX) begin
                    fill_nxt = fill_q + FILL_W'(1);
                end
            end
            default: fill_nxt = fill_q;
        endcase
    end

    // Occupancy and FULL registers; FULL is registered from the next count so it
    // asserts on the same edge the DEPTH-th valid sample arrives.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fill_q <= '0;
            full_q <= 1'b0;
        end else begin
            fill_q <= fill_nxt;
            full_q <= (fill_nxt == FILL_MAX);
        end
    end

    assign bus.Q    = stage_q[DEPTH-1];
    assign bus.TAPS = taps;
    assign bus.FILL = fill_q;
    assign bus.FULL = full_q;

endmodule
